// File: rtl/md_sched.sv
// HI/LO multiply-divide scheduler: accepts mult/div from E, runs a fixed-latency busy
// window, then commits the result to HI/LO. Also handles mthi/mtlo and mfhi/mflo reads.
module md_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_HILOOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_md,
  input  logic        D_mf,
  input  logic        D_mt,
  input  logic        Req,
  output logic        busy,
  output logic        start,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_HILOOut
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam logic [3:0] MultCycles = 4'd5;
  localparam logic [3:0] DivCycles  = 4'd10;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_md_op;
  logic        accept;
  logic        done;
  logic        mt_ok;

  assign is_md_op = (E_HILOOp >= OpMult) && (E_HILOOp <= OpDivu);
  assign accept   = is_md_op && (state_q == StIdle) && !Req;
  // Last busy cycle: result commits at the edge that ends it.
  assign done     = (state_q == StBusy) && (cnt_q == 4'd1);
  assign mt_ok    = (state_q == StIdle) && !Req;

  // Datapath, evaluated from the latched operands.
  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] quot, rem;
  logic [31:0] div_lo, div_hi;
  logic        is_mul_q;

  always_comb begin
    is_mul_q = (op_q == OpMult) || (op_q == OpMultu);
    if (op_q == OpMult) begin
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    end else begin
      prod = {32'b0, a_q} * {32'b0, b_q};
    end
    // Sign-magnitude division so that 0x80000000 / -1 yields 0x80000000 without overflow.
    a_neg  = (op_q == OpDiv) && a_q[31];
    b_neg  = (op_q == OpDiv) && b_q[31];
    a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    quot   = a_mag / b_safe;
    rem    = a_mag % b_safe;
    div_lo = (a_neg ^ b_neg) ? (~quot + 32'd1) : quot;
    div_hi = a_neg ? (~rem + 32'd1) : rem;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = (E_HILOOp <= OpMultu) ? MultCycles : DivCycles;
          op_d    = E_HILOOp;
          a_d     = E_A;
          b_d     = E_B;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // HI/LO update: completion and mthi/mtlo are mutually exclusive by state.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (done) begin
      if (is_mul_q) begin
        hi_d = prod[63:32];
        lo_d = prod[31:0];
      end else if (b_q != 32'd0) begin
        hi_d = div_hi;
        lo_d = div_lo;
      end
    end else if (mt_ok) begin
      if (E_HILOOp == OpMthi) begin
        hi_d = E_A;
      end else if (E_HILOOp == OpMtlo) begin
        lo_d = E_A;
      end
    end
  end

  // Outputs.
  always_comb begin
    busy  = (state_q == StBusy);
    start = accept;
    stall = (D_md || D_mf || D_mt) && (accept || (state_q == StBusy));
    HI    = hi_q;
    LO    = lo_q;
    case (E_HILOOp)
      OpMfhi:  E_HILOOut = hi_q;
      OpMflo:  E_HILOOut = lo_q;
      default: E_HILOOut = 32'd0;
    endcase
  end

endmodule
